// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response, EX redirect and IF/ID output.
// master = fetch queue, slave = surrounding pipeline/memory.
interface riscv_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          imem_req_valid;
    logic [31:0]   imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          out_ready;
    logic [CW-1:0] fq_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        output fq_count
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        input  fq_count
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// In-order instruction fetch queue with redirect flush and drop counting for stale responses.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to out_* when it fills the head entry.
module riscv_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clock,
    input logic                 reset,
    riscv_fetch_queue_if.master fq
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0] head_q, fill_q, tail_q;
    logic [CW-1:0] count_q, pend_q, drop_q;
    logic [31:0]   fetch_pc_q;

    logic          req_valid, alloc, fill_en, drop_rsp;
    logic          stored_valid, bypass_hit, out_valid_c, pop;
    logic [CW:0]   budget;
    logic [31:0]   out_instr_c, out_pc_c;

    always_comb begin
        budget       = {1'b0, drop_q} + {1'b0, count_q};
        // Stale responses still owed reserve slots so total outstanding never exceeds DEPTH.
        req_valid    = reset && !fq.redirect_valid && (count_q < DEPTH_C) && (budget < {1'b0, DEPTH_C});
        alloc        = req_valid && fq.imem_req_ready;
        drop_rsp     = fq.imem_rsp_valid && (drop_q != '0);
        fill_en      = fq.imem_rsp_valid && (drop_q == '0) && !fq.redirect_valid;
        stored_valid = filled_q[head_q] && (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit   = fill_en && !stored_valid && (fill_q == head_q) && (count_q != '0);
`else
        bypass_hit   = 1'b0;
`endif
        out_valid_c  = !fq.redirect_valid && (stored_valid || bypass_hit);
        pop          = out_valid_c && fq.out_ready;
    end

    always_comb begin
        out_instr_c = '0;
        out_pc_c    = '0;
        if (out_valid_c) begin
            out_pc_c    = pc_q[head_q];
`ifdef FETCH_QUEUE_BYPASS_EN
            out_instr_c = bypass_hit ? fq.imem_rsp_data : instr_q[head_q];
`else
            out_instr_c = instr_q[head_q];
`endif
        end
    end

    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = fetch_pc_q;
    assign fq.out_valid      = out_valid_c;
    assign fq.out_instr      = out_instr_c;
    assign fq.out_pc         = out_pc_c;
    assign fq.fq_count       = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
            fetch_pc_q <= RESET_PC;
        end else if (fq.redirect_valid) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            filled_q   <= '0;
            // A response arriving this cycle retires one of the old-stream outstanding requests.
            drop_q     <= drop_q + pend_q - CW'(fq.imem_rsp_valid);
            fetch_pc_q <= {fq.redirect_pc[31:2], 2'b00};
        end else begin
            if (alloc) begin
                tail_q           <= tail_q + PW'(1);
                filled_q[tail_q] <= 1'b0;
                fetch_pc_q       <= fetch_pc_q + 32'd4;
            end
            if (drop_rsp) begin
                drop_q <= drop_q - CW'(1);
            end
            if (fill_en) begin
                fill_q <= fill_q + PW'(1);
                if (!(bypass_hit && pop)) begin
                    filled_q[fill_q] <= 1'b1;
                end
            end
            if (pop) begin
                head_q           <= head_q + PW'(1);
                filled_q[head_q] <= 1'b0;
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
            pend_q  <= pend_q + CW'(alloc) - CW'(fill_en);
        end
    end

    always_ff @(posedge clock) begin
        if (alloc) begin
            pc_q[tail_q] <= fetch_pc_q;
        end
        if (fill_en) begin
            instr_q[fill_q] <= fq.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios plus a randomized run against a counting model.
// The memory responder returns words in order with a configurable 1..N cycle latency.
`timescale 1ns/1ps
module tb_riscv_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    riscv_fetch_queue_if #(.DEPTH(DEPTH)) fq ();
    riscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock),
        .reset(reset),
        .fq   (fq)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat_min  = 1;
    int lat_max  = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Instruction memory: answers every accepted request, in order, regardless of reset/redirect.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            fq.imem_rsp_valid = 1'b1;
            fq.imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            fq.imem_rsp_valid = 1'b0;
            fq.imem_rsp_data  = $urandom;
        end
    end

    always @(negedge clock) begin
        if (fq.imem_rsp_valid) void'(memq.pop_front());
        if (fq.imem_req_valid && fq.imem_req_ready)
            memq.push_back('{addr: fq.imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic rdy, input logic ordy, input logic redir, input logic [31:0] rpc);
        fq.imem_req_ready = rdy;
        fq.out_ready      = ordy;
        fq.redirect_valid = redir;
        fq.redirect_pc    = rpc;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (8) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'h0);
        end
        @(negedge clock);
        checks++; if (fq.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", fq.imem_req_valid); end
        checks++; if (fq.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", fq.out_valid); end
        checks++; if (fq.out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr got=%h exp=0", fq.out_instr); end
        checks++; if (fq.out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc got=%h exp=0", fq.out_pc); end
        checks++; if (fq.fq_count !== CW'(0)) begin failures++; $display("FAIL rst_count got=%0d exp=0", fq.fq_count); end
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (fq.imem_req_valid !== 1'b1) begin failures++; $display("FAIL rel_req_valid got=%b exp=1", fq.imem_req_valid); end
        checks++; if (fq.imem_req_addr !== RESET_PC) begin failures++; $display("FAIL rel_req_addr got=%h exp=%h", fq.imem_req_addr, RESET_PC); end
        checks++; if (fq.out_valid !== 1'b0) begin failures++; $display("FAIL rel_out_valid got=%b exp=0", fq.out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] req_a[$], pop_pc[$], pop_in[$];
        int          req_c[$];
        logic [31:0] ga, gp, gi;
        int          gc;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clock);
            if (fq.imem_req_valid && fq.imem_req_ready) begin req_a.push_back(fq.imem_req_addr); req_c.push_back(i); end
            if (fq.out_valid && fq.out_ready) begin pop_pc.push_back(fq.out_pc); pop_in.push_back(fq.out_instr); end
        end
        for (int k = 0; k < 3; k++) begin
            ga = (k < req_a.size())  ? req_a[k]  : 32'hxxxx_xxxx;
            gc = (k < req_c.size())  ? req_c[k]  : -1;
            gp = (k < pop_pc.size()) ? pop_pc[k] : 32'hxxxx_xxxx;
            gi = (k < pop_in.size()) ? pop_in[k] : 32'hxxxx_xxxx;
            checks++; if (ga !== 32'(4 * k)) begin failures++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", k, ga, 32'(4 * k)); end
            checks++; if (gc !== k) begin failures++; $display("FAIL stream_req_cycle[%0d] got=%0d exp=%0d", k, gc, k); end
            checks++; if (gp !== 32'(4 * k)) begin failures++; $display("FAIL stream_out_pc[%0d] got=%h exp=%h", k, gp, 32'(4 * k)); end
            checks++; if (gi !== mem_word(32'(4 * k))) begin failures++; $display("FAIL stream_out_instr[%0d] got=%h exp=%h", k, gi, mem_word(32'(4 * k))); end
        end
    endtask

    task automatic test_stall();
        int   n_req = 0;
        logic stable = 1'b1;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clock);
            if (fq.imem_req_valid && fq.imem_req_ready) n_req++;
            if (fq.out_valid && (fq.out_pc !== 32'h0 || fq.out_instr !== mem_word(32'h0))) stable = 1'b0;
        end
        checks++; if (n_req !== 4) begin failures++; $display("FAIL stall_requests got=%0d exp=4", n_req); end
        checks++; if (fq.fq_count !== CW'(4)) begin failures++; $display("FAIL stall_count got=%0d exp=4", fq.fq_count); end
        checks++; if (fq.imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", fq.imem_req_valid); end
        checks++; if (fq.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%b exp=1", fq.out_valid); end
        checks++; if (fq.out_pc !== 32'h0) begin failures++; $display("FAIL stall_out_pc got=%h exp=0", fq.out_pc); end
        checks++; if (fq.out_instr !== mem_word(32'h0)) begin failures++; $display("FAIL stall_out_instr got=%h exp=%h", fq.out_instr, mem_word(32'h0)); end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL stall_stable got=%b exp=1", stable); end
    endtask

    task automatic test_redirect();
        int          n_req = 0, n_bad = 0, n_pop = 0;
        logic [31:0] first_pc = 32'hxxxx_xxxx, first_in = 32'hxxxx_xxxx;
        lat_min = 4; lat_max = 4;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clock);
            if (fq.imem_req_valid && fq.imem_req_ready) n_req++;
        end
        checks++; if (n_req !== 3) begin failures++; $display("FAIL redir_inflight got=%0d exp=3", n_req); end
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        @(negedge clock);
        checks++; if (fq.imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_req_blocked got=%b exp=0", fq.imem_req_valid); end
        for (int i = 0; i < 30; i++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clock);
            if (i == 0) begin
                checks++; if (fq.imem_req_valid !== 1'b1) begin failures++; $display("FAIL redir_next_valid got=%b exp=1", fq.imem_req_valid); end
                checks++; if (fq.imem_req_addr !== 32'h100) begin failures++; $display("FAIL redir_next_addr got=%h exp=00000100", fq.imem_req_addr); end
            end
            if (fq.out_valid && fq.out_ready) begin
                if (n_pop == 0) begin first_pc = fq.out_pc; first_in = fq.out_instr; end
                if (fq.out_pc !== 32'(32'h100 + 4 * n_pop) || fq.out_instr !== mem_word(32'(32'h100 + 4 * n_pop))) n_bad++;
                n_pop++;
            end
        end
        checks++; if (first_pc !== 32'h100) begin failures++; $display("FAIL redir_first_pc got=%h exp=00000100", first_pc); end
        checks++; if (first_in !== mem_word(32'h100)) begin failures++; $display("FAIL redir_first_instr got=%h exp=%h", first_in, mem_word(32'h100)); end
        checks++; if (n_bad !== 0 || n_pop < 3) begin failures++; $display("FAIL redir_sequence bad=%0d pops=%0d exp bad=0 pops>=3", n_bad, n_pop); end
    endtask

    task automatic test_redirect_rsp();
        logic [31:0] first_pc = 32'hxxxx_xxxx;
        int          n_pop = 0;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, 32'h0);
        end
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0240);
        @(negedge clock);
        checks++; if (fq.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_pop got=%b exp=0", fq.out_valid); end
        checks++; if (fq.imem_req_valid !== 1'b0) begin failures++; $display("FAIL flush_req_valid got=%b exp=0", fq.imem_req_valid); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (fq.fq_count !== CW'(0)) begin failures++; $display("FAIL flush_count got=%0d exp=0", fq.fq_count); end
        checks++; if (fq.out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_valid got=%b exp=0", fq.out_valid); end
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clock);
            if (fq.out_valid && fq.out_ready) begin
                if (n_pop == 0) first_pc = fq.out_pc;
                n_pop++;
            end
        end
        checks++; if (first_pc !== 32'h240) begin failures++; $display("FAIL flush_first_pc got=%h exp=00000240", first_pc); end
    endtask

    task automatic test_reset_mid();
        int n_req = 0, n_bad = 0, n_pop = 0;
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clock);
            if (fq.imem_req_valid && fq.imem_req_ready) n_req++;
        end
        checks++; if (n_req !== 2) begin failures++; $display("FAIL midrst_outstanding got=%0d exp=2", n_req); end
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (fq.imem_req_valid !== 1'b0 || fq.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_quiet req=%b out=%b exp 0 0", fq.imem_req_valid, fq.out_valid); end
        repeat (6) tick();
        tick();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (fq.imem_req_valid !== 1'b1) begin failures++; $display("FAIL midrst_req_valid got=%b exp=1", fq.imem_req_valid); end
        checks++; if (fq.imem_req_addr !== RESET_PC) begin failures++; $display("FAIL midrst_req_addr got=%h exp=%h", fq.imem_req_addr, RESET_PC); end
        for (int i = 0; i < 12; i++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            @(negedge clock);
            if (fq.out_valid && fq.out_ready) begin
                if (fq.out_pc !== 32'(RESET_PC + 4 * n_pop) || fq.out_instr !== mem_word(32'(RESET_PC + 4 * n_pop))) n_bad++;
                n_pop++;
            end
        end
        checks++; if (n_bad !== 0 || n_pop < 3) begin failures++; $display("FAIL midrst_sequence bad=%0d pops=%0d exp bad=0 pops>=3", n_bad, n_pop); end
    endtask

    task automatic test_bypass();
        lat_min = 1; lat_max = 1;
        do_reset();
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (fq.out_valid !== 1'b1) begin failures++; $display("FAIL bypass_same_valid got=%b exp=1", fq.out_valid); end
        checks++; if (fq.out_instr !== 32'h0000_0013) begin failures++; $display("FAIL bypass_same_instr got=%h exp=00000013", fq.out_instr); end
        checks++; if (fq.out_pc !== 32'h0) begin failures++; $display("FAIL bypass_same_pc got=%h exp=0", fq.out_pc); end
        tick();
        @(negedge clock);
        checks++; if (fq.out_valid !== 1'b0) begin failures++; $display("FAIL bypass_after_valid got=%b exp=0", fq.out_valid); end
        checks++; if (fq.fq_count !== CW'(0)) begin failures++; $display("FAIL bypass_after_count got=%0d exp=0", fq.fq_count); end
`else
        checks++; if (fq.out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_same_valid got=%b exp=0", fq.out_valid); end
        tick();
        @(negedge clock);
        checks++; if (fq.out_valid !== 1'b1) begin failures++; $display("FAIL nobypass_next_valid got=%b exp=1", fq.out_valid); end
        checks++; if (fq.out_instr !== 32'h0000_0013) begin failures++; $display("FAIL nobypass_next_instr got=%h exp=00000013", fq.out_instr); end
        checks++; if (fq.out_pc !== 32'h0) begin failures++; $display("FAIL nobypass_next_pc got=%h exp=0", fq.out_pc); end
`endif
    endtask

    // Model: current stream issues and retires consecutive words; responses owed to
    // earlier streams are counted as "old" and must be consumed before new data lands.
    task automatic test_random();
        int          m_count = 0, m_avail = 0, m_pend = 0, m_old = 0;
        logic [31:0] exp_req = RESET_PC, exp_pop = RESET_PC;
        logic        byp = 1'b0;
        logic        rdy, ordy, redir, rsp, e_req, e_out, acc, pop, fill;
        logic [31:0] rpc;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = 1'b1;
`endif
        lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            tick();
            rdy   = ($urandom_range(3, 0) != 0);
            ordy  = ($urandom_range(9, 0) < 7);
            redir = ($urandom_range(24, 0) == 0);
            rpc   = $urandom;
            drive(rdy, ordy, redir, rpc);
            @(negedge clock);
            rsp   = fq.imem_rsp_valid;
            e_req = !redir && (m_count < int'(DEPTH)) && (m_old + m_count < int'(DEPTH));
            e_out = !redir && ((m_avail > 0) || (byp && rsp && m_old == 0 && m_count > 0));
            checks++; if (fq.imem_req_valid !== e_req) begin failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", i, fq.imem_req_valid, e_req); end
            if (e_req) begin
                checks++; if (fq.imem_req_addr !== exp_req) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", i, fq.imem_req_addr, exp_req); end
            end
            checks++; if (fq.fq_count !== CW'(m_count)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, fq.fq_count, m_count); end
            checks++; if (fq.out_valid !== e_out) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, fq.out_valid, e_out); end
            if (e_out) begin
                checks++; if (fq.out_pc !== exp_pop) begin failures++; $display("FAIL rnd_out_pc cyc=%0d got=%h exp=%h", i, fq.out_pc, exp_pop); end
                checks++; if (fq.out_instr !== mem_word(exp_pop)) begin failures++; $display("FAIL rnd_out_instr cyc=%0d got=%h exp=%h", i, fq.out_instr, mem_word(exp_pop)); end
            end
            acc = e_req && rdy;
            pop = e_out && ordy;
            if (redir) begin
                m_old   = m_old + m_pend - (rsp ? 1 : 0);
                m_pend  = 0;
                m_count = 0;
                m_avail = 0;
                exp_req = rpc & 32'hFFFF_FFFC;
                exp_pop = rpc & 32'hFFFF_FFFC;
            end else begin
                fill = 1'b0;
                if (rsp) begin
                    if (m_old > 0) m_old--;
                    else begin m_pend--; fill = 1'b1; end
                end
                m_avail = m_avail + (fill ? 1 : 0) - (pop ? 1 : 0);
                m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
                m_pend  = m_pend + (acc ? 1 : 0);
                if (acc) exp_req = exp_req + 32'd4;
                if (pop) exp_pop = exp_pop + 32'd4;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rsp();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
